// File: rtl/sdram_arbiter_pkg.sv
// sdram_arbiter_pkg: shared SDRAM widths, command encodings and arbiter state codes
package sdram_arbiter_pkg;
    localparam int SDRAM_ADDR_BITS = 12;
    localparam int SDRAM_BA_BITS   = 2;
    // commands are {CS_n, RAS_n, CAS_n, WE_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_ARB   = 3'd1;
    localparam logic [2:0] ST_AREF  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_READ  = 3'd4;
endpackage

// File: rtl/sdram_arbiter_cmd_mux.sv
// sdram_arbiter_cmd_mux: routes the granted engine's command, address and bank to the SDRAM pins
module sdram_arbiter_cmd_mux
    import sdram_arbiter_pkg::*;
#(
    parameter int ADDR_BITS = SDRAM_ADDR_BITS,
    parameter int BA_BITS   = SDRAM_BA_BITS
) (
    input  logic [2:0]           state,
    input  logic [3:0]           init_cmd,
    input  logic [ADDR_BITS-1:0] init_addr,
    input  logic [3:0]           aref_cmd,
    input  logic [ADDR_BITS-1:0] aref_addr,
    input  logic [3:0]           wr_cmd,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [BA_BITS-1:0]   wr_ba,
    input  logic [3:0]           rd_cmd,
    input  logic [ADDR_BITS-1:0] rd_addr,
    input  logic [BA_BITS-1:0]   rd_ba,
    output logic [3:0]           sdram_cmd,
    output logic [ADDR_BITS-1:0] sdram_addr,
    output logic [BA_BITS-1:0]   sdram_ba
);
    always_comb begin
        sdram_cmd  = state == ST_INIT  ? init_cmd  :
                     state == ST_AREF  ? aref_cmd  :
                     state == ST_WRITE ? wr_cmd    :
                     state == ST_READ  ? rd_cmd    : CMD_NOP;
        sdram_addr = state == ST_INIT  ? init_addr :
                     state == ST_AREF  ? aref_addr :
                     state == ST_WRITE ? wr_addr   :
                     state == ST_READ  ? rd_addr   : '0;
        sdram_ba   = state == ST_WRITE ? wr_ba     :
                     state == ST_READ  ? rd_ba     : '0;
    end
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: grants init/refresh/write/read engines one at a time and drives the SDRAM bus.
// SDRAM_ARB_RR_EN selects round-robin between write and read; otherwise write beats read.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int ADDR_BITS = SDRAM_ADDR_BITS,
    parameter int BA_BITS   = SDRAM_BA_BITS
) (
    input  logic                 sdram_clk,
    input  logic                 rst_n,
    input  logic                 init_done,
    input  logic [3:0]           init_cmd,
    input  logic [ADDR_BITS-1:0] init_addr,
    input  logic                 aref_req,
    input  logic                 aref_done,
    input  logic [3:0]           aref_cmd,
    input  logic [ADDR_BITS-1:0] aref_addr,
    input  logic                 wr_req,
    input  logic                 rd_req,
    input  logic                 wr_done,
    input  logic                 rd_done,
    input  logic [3:0]           wr_cmd,
    input  logic [3:0]           rd_cmd,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [ADDR_BITS-1:0] rd_addr,
    input  logic [BA_BITS-1:0]   wr_ba,
    input  logic [BA_BITS-1:0]   rd_ba,
    output logic                 aref_en,
    output logic                 wr_en,
    output logic                 rd_en,
    output logic                 aref_overrun,
    output logic [3:0]           sdram_cmd,
    output logic [ADDR_BITS-1:0] sdram_addr,
    output logic [BA_BITS-1:0]   sdram_ba
);
    logic [2:0] state;
    logic       aref_pend;
    logic       wr_sel;
    logic       rd_sel;
    logic       aref_grant;
`ifdef SDRAM_ARB_RR_EN
    logic last_wr;
    assign wr_sel = wr_req && !(rd_req && last_wr);
    always_ff @(posedge sdram_clk or negedge rst_n) begin
        if (!rst_n)
            last_wr <= 1'b0;
        else if (state == ST_ARB && !aref_pend && (wr_req || rd_req))
            last_wr <= wr_sel;
    end
`else
    assign wr_sel = wr_req;
`endif
    assign rd_sel     = rd_req && !wr_sel;
    assign aref_grant = state == ST_ARB && aref_pend;
    always_ff @(posedge sdram_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_INIT;
            aref_en      <= 1'b0;
            wr_en        <= 1'b0;
            rd_en        <= 1'b0;
            aref_pend    <= 1'b0;
            aref_overrun <= 1'b0;
        end else begin
            aref_en <= 1'b0;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
            // a new request in the grant cycle re-arms the pending flag
            if (aref_req && state != ST_INIT)
                aref_pend <= 1'b1;
            else if (aref_grant)
                aref_pend <= 1'b0;
            if (aref_req && aref_pend)
                aref_overrun <= 1'b1;
            case (state)
                ST_INIT:  if (init_done) state <= ST_ARB;
                ST_ARB: begin
                    if (aref_pend) begin
                        state   <= ST_AREF;
                        aref_en <= 1'b1;
                    end else if (wr_sel) begin
                        state <= ST_WRITE;
                        wr_en <= 1'b1;
                    end else if (rd_sel) begin
                        state <= ST_READ;
                        rd_en <= 1'b1;
                    end
                end
                ST_AREF:  if (aref_done) state <= ST_ARB;
                ST_WRITE: if (wr_done) state <= ST_ARB;
                ST_READ:  if (rd_done) state <= ST_ARB;
                default:  state <= ST_INIT;
            endcase
        end
    end
    sdram_arbiter_cmd_mux #(.ADDR_BITS(ADDR_BITS), .BA_BITS(BA_BITS)) u_cmd_mux (
        .state      (state),
        .init_cmd   (init_cmd),
        .init_addr  (init_addr),
        .aref_cmd   (aref_cmd),
        .aref_addr  (aref_addr),
        .wr_cmd     (wr_cmd),
        .wr_addr    (wr_addr),
        .wr_ba      (wr_ba),
        .rd_cmd     (rd_cmd),
        .rd_addr    (rd_addr),
        .rd_ba      (rd_ba),
        .sdram_cmd  (sdram_cmd),
        .sdram_addr (sdram_addr),
        .sdram_ba   (sdram_ba)
    );
endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Central command arbiter of the SDRAM controller, sitting directly downstream of the initialize, auto-refresh, write and read engines and upstream of the SDRAM pins. It latches the one-cycle refresh request, grants exactly one engine at a time via one-cycle enable pulses, and muxes the granted engine's command/address onto the SDRAM bus. Refresh has highest priority; a granted write/read is never pre-empted.

## Interface
- ADDR_BITS, 12, SDRAM address width (A11..A0)
- BA_BITS, 2, bank address width
- sdram_clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- init_done  in  1  initialization complete (level, stays high)
- init_cmd / init_addr  in  4 / ADDR_BITS  init engine command {CS_n,RAS_n,CAS_n,WE_n} and address
- aref_req  in  1  refresh request, one-cycle pulse every 15 us
- aref_done  in  1  refresh sequence finished (one-cycle pulse)
- aref_cmd / aref_addr  in  4 / ADDR_BITS  refresh engine command/address
- wr_req, rd_req  in  1  write/read request, level, held until granted
- wr_done, rd_done  in  1  burst finished (one-cycle pulse)
- wr_cmd, rd_cmd  in  4  write/read engine command
- wr_addr, rd_addr  in  ADDR_BITS  write/read engine address
- wr_ba, rd_ba  in  BA_BITS  write/read bank address
- aref_en, wr_en, rd_en  out  1  grant pulses, one cycle
- aref_overrun  out  1  sticky: refresh request arrived while one already pending
- sdram_cmd  out  4  command to pins
- sdram_addr  out  ADDR_BITS  address to pins
- sdram_ba  out  BA_BITS  bank address to pins

## Operation
- States: INIT, ARB, AREF, WRITE, READ (registered, 3-bit encoding).
- INIT: output init_cmd/init_addr, sdram_ba=0; go to ARB when init_done=1. aref_req ignored in INIT.
- aref_pend: set on aref_req (in any state except INIT), cleared on the cycle aref_en is driven; set wins over clear.
- aref_overrun: set when aref_req=1 and aref_pend=1; cleared only by reset.
- ARB: sdram_cmd=NOP (4'b0111), addr=0, ba=0. Priority aref_pend > wr_req > rd_req. Selection registers the next state and the matching *_en pulse on the same edge.
- AREF: mux aref_cmd/aref_addr, ba=0; on aref_done -> ARB.
- WRITE: mux wr_cmd/wr_addr/wr_ba; on wr_done -> ARB. READ: same with rd_*.
- A done pulse from a non-granted engine is ignored.
- Refresh arriving during WRITE/READ waits until done; it is granted from the following ARB cycle.

## Timing
- Reset values: state=INIT, all *_en=0, aref_pend=0, aref_overrun=0, sdram_cmd=init_cmd (combinational), sdram_ba=0.
- sdram_cmd/addr/ba are a combinational mux of the current state; zero latency from engine to pins.
- Grant: request seen in ARB at edge N -> state and *_en high during cycle N+1, *_en low from N+2.
- done seen at edge M -> ARB during M+1; earliest next grant visible in M+2 (minimum one NOP cycle between grants).
- Reset mid-burst: immediate return to INIT, enables drop asynchronously, pending refresh discarded.

## Configuration
- SDRAM_ARB_RR_EN defined: write/read use round-robin; a last_wr flag records the last granted of the two, and when both request the other one wins. Refresh still highest.
- Undefined: fixed priority write > read; last_wr flag absent.

## Structure
- Command encodings (NOP, PRE, AREF, ACT, WR, RD) and state encodings go in the shared sdr_parameters.vh, with ADDR_BITS/BA_BITS.
- One natural sub-module: sdram_cmd_mux (pure state-indexed mux of cmd/addr/ba); FSM, pending and overrun logic stay in the top.

## Test plan
- Reset with init_cmd=4'b0010 -> sdram_cmd=4'b0010, all enables 0; init_done rises -> ARB next cycle, sdram_cmd=4'b0111.
- aref_req pulse in ARB -> aref_en high exactly one cycle next cycle, sdram_cmd follows aref_cmd; aref_done -> NOP one cycle.
- wr_req and rd_req held together (macro off) -> wr_en, after wr_done -> rd_en; macro on with repeated requests -> grants alternate W,R,W,R.
- aref_req pulse during WRITE -> no aref_en until wr_done; aref_en issued before pending rd_req.
- Two aref_req pulses during one long READ -> aref_overrun=1, stays 1 after the refresh completes.
- rst_n low mid-WRITE -> state INIT, wr_en=0, aref_pend=0 immediately; no grant until init_done.
